vpm_ingress_stage: RTL and testbench

//  Elastic entry stage feeding the first VPM pipeline stage (I) from a valid/ready producer.
//  - 2-entry skid buffer: full throughput, registered in_ready, no combinational ready path.
//  - Honours the pipeline's active-low flush and reports discarded-item statistics.
//  - Sits between an external stream source and the pipeline's stage-I data/valid inputs.

---
 rtl/vpm_pkg.sv | 15 +
 rtl/vpm_sat_counter.sv | 40 ++++
 rtl/vpm_ingress_stage.sv | 114 +++++++++++
 tb/tb_vpm_ingress_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpm_pkg.sv
// Shared types and constants for the VPM ingress stage.
// Occupancy encoding plus a helper that derives it from the two entry-valid bits.
package vpm_pkg;

  typedef logic [1:0] vpm_occ_t;

  localparam vpm_occ_t VPM_OCC_EMPTY = 2'd0;
  localparam vpm_occ_t VPM_OCC_FULL1 = 2'd1;
  localparam vpm_occ_t VPM_OCC_FULL2 = 2'd2;

  function automatic vpm_occ_t vpm_occ(input logic main_valid, input logic skid_valid);
    return vpm_occ_t'({1'b0, main_valid}) + vpm_occ_t'({1'b0, skid_valid});
  endfunction

endpackage

// File: rtl/vpm_sat_counter.sv
// Saturating up-counter with a small per-cycle increment (0..3) and synchronous clear.
// Sticks at all-ones instead of wrapping.
module vpm_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] sum;

  always_comb begin
    sum   = {2'b00, cnt_q} + {{WIDTH{1'b0}}, inc};
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (sum > {2'b00, CntMax}) begin
      cnt_d = CntMax;
    end else begin
      cnt_d = sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vpm_ingress_stage.sv
// Two-entry skid buffer in front of VPM stage I, with registered in_ready,
// active-low synchronous flush and a saturating count of words discarded by flush.
module vpm_ingress_stage
  import vpm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  flush_n,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  in_ready_q, in_ready_d;
  vpm_occ_t              occ_q, occ_d;

  logic       accept;
  logic       deliver;
  logic [1:0] flush_inc;

  always_comb begin
    accept       = in_valid & in_ready_q;
    deliver      = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    flush_inc    = 2'd0;

    if (!flush_n) begin
      // A word delivered this cycle was consumed by stage I, so it is not counted.
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      flush_inc    = {1'b0, main_valid_q & ~deliver} + {1'b0, skid_valid_q} + {1'b0, accept};
    end else begin
      case (occ_q)
        VPM_OCC_EMPTY: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
        VPM_OCC_FULL1: begin
          if (accept && deliver) begin
            main_data_d = in_data;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end else if (deliver) begin
            main_valid_d = 1'b0;
          end
        end
        VPM_OCC_FULL2: begin
          if (deliver) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    in_ready_d = ~skid_valid_d;
    occ_d      = vpm_occ(main_valid_d, skid_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      occ_q        <= VPM_OCC_EMPTY;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
    end
  end

  vpm_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_vpm_ingress_stage.sv
// Self-checking bench for vpm_ingress_stage: directed vector table plus model-checked
// sequences; a second instance with a 2-bit counter exercises saturation.
module tb_vpm_ingress_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       flush_n = 1'b1;

  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [7:0] flush_cnt;

  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [1:0] s_occupancy;
  logic [1:0] s_flush_cnt;

  always #5 clk = ~clk;

  vpm_ingress_stage u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush_n  (flush_n),
    .occupancy(occupancy),
    .flush_cnt(flush_cnt)
  );

  vpm_ingress_stage #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (2)
  ) u_dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (s_in_ready),
    .in_data  (in_data),
    .out_valid(s_out_valid),
    .out_ready(out_ready),
    .out_data (s_out_data),
    .flush_n  (flush_n),
    .occupancy(s_occupancy),
    .flush_cnt(s_flush_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of held words and an unbounded discard count.
  logic [7:0] mq[$];
  int         mcnt;
  int         n_acc, n_del;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_model();
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("flush_cnt", 32'(flush_cnt), 32'(min_i(mcnt, 255)));
    chk("flush_cnt_w2", 32'(s_flush_cnt), 32'(min_i(mcnt, 3)));
  endtask

  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic fn,
                     output logic acc);
    logic del;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush_n   = fn;
    acc = iv && (mq.size() < 2);
    del = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (del) n_del++;
    if (acc) n_acc++;
    if (!fn) begin
      mcnt += mq.size() - (del ? 1 : 0) + (acc ? 1 : 0);
      mq.delete();
    end else begin
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    #1 check_model();
  endtask

  // Asserts reset between clock edges and checks the outputs respond immediately.
  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_flush_cnt_w2", 32'(s_flush_cnt), 32'd0);
    mq.delete();
    mcnt  = 0;
    n_acc = 0;
    n_del = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fn;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    logic [1:0] occ;
    logic [7:0] cnt;
    logic [1:0] scnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic acc;
    logic pend_v;
    logic [7:0] pend_d;
    logic iv, ordy, fn;
    logic [7:0] d;

    //             iv  d      rdy fn   ov  od     ir  occ  cnt   scnt
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 2'd1, 8'd0, 2'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 8'd0, 2'd0};
    vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 2'd1, 8'd0, 2'd0};
    vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 2'd2, 8'd0, 2'd0};
    vecs[4]  = '{1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 2'd2, 8'd0, 2'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1, 8'd0, 2'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 8'd0, 2'd0};
    vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1, 8'd0, 2'd0};
    vecs[8]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 2'd2, 8'd0, 2'd0};
    // Flush at occupancy 2: 55 is offered but in_ready is low, so only 2 are discarded.
    vecs[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'd2, 2'd2};
    vecs[10] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 2'd1, 8'd2, 2'd2};
    // 66 delivered during flush is not counted; 77 accepted and discarded is.
    vecs[11] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'd3, 2'd3};
    vecs[12] = '{1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 8'd4, 2'd3};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 8'd4, 2'd3};

    do_reset();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      flush_n   = vecs[i].fn;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_flush_cnt_w2", i), 32'(s_flush_cnt), 32'(vecs[i].scnt));
    end

    // Back-to-back stream with a ready consumer: one word per cycle, in order.
    do_reset();
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b1, 1'b1, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("stream_accepted", 32'(n_acc), 32'd16);
    chk("stream_delivered", 32'(n_del), 32'd16);

    // Two full flushes: 2-bit counter must stop at 3, not wrap.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      cyc(1'b1, 8'(8'hC0 + 2 * r), 1'b0, 1'b1, acc);
      cyc(1'b1, 8'(8'hC1 + 2 * r), 1'b0, 1'b1, acc);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, acc);
    end
    chk("sat_flush_cnt", 32'(flush_cnt), 32'd4);
    chk("sat_flush_cnt_w2", 32'(s_flush_cnt), 32'd3);

    // Random traffic against the model; producer holds its word until accepted.
    do_reset();
    pend_v = 1'b0;
    pend_d = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (pend_v) begin
        iv = 1'b1;
        d  = pend_d;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        d  = 8'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      fn   = ($urandom_range(0, 63) != 0);
      cyc(iv, d, ordy, fn, acc);
      pend_v = iv && !acc;
      pend_d = d;
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("rand_drained", 32'(occupancy), 32'd0);
    chk("rand_conservation", 32'(flush_cnt), 32'(min_i(n_acc - n_del, 255)));

    // Reset in the middle of activity.
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, acc);
    cyc(1'b1, 8'h5B, 1'b0, 1'b1, acc);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h5C, 1'b0, 1'b1, acc);
    do_reset();
    cyc(1'b1, 8'h5D, 1'b1, 1'b1, acc);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
